// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n -- N-way round-robin arbiter with bounded hold.
//
// The current grantee keeps the grant while it keeps requesting. If another
// requester is waiting, it is allowed at most MAX_HOLD consecutive cycles before
// the grant rotates to the next requester after it in circular order. Handover
// is back-to-back, with no idle cycle between grantees. All outputs are
// registered, so there is no combinational path from req to grant.
//
// Parameters:
//   N         number of requesters (>= 2)
//   MAX_HOLD  max consecutive grant cycles while another requester waits (>= 1)
//   IDXW      width of grant_idx, derived from N
//
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous reset, active-low
//   req        [N-1:0]    level request vector, bit i = requester i
//   grant      [N-1:0]    registered one-hot grant, all-zero when idle
//   grant_idx  [IDXW-1:0] index of the granted requester, 0 when idle
//   grant_vld  1          |grant
module rr_arbiter_n #(
  parameter int N        = 32,
  parameter int MAX_HOLD = 1,
  parameter int IDXW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_vld
);

  localparam int              HCW       = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IDXW-1:0] PTR_RST   = IDXW'(N - 1);

  generate
    if (N < 2) begin : g_bad_n
      $error("rr_arbiter_n: N must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
      $error("rr_arbiter_n: MAX_HOLD must be >= 1");
    end
  endgenerate

  // Returns the first set bit of v in the order from+1, from+2, ..., wrapping
  // modulo N and ending at from. Returns 0 when v is all-zero.
  function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0]    v,
                                              input logic [IDXW-1:0] from);
    logic [IDXW-1:0] sel;
    logic [IDXW-1:0] jj;
    logic            found;
    int              j;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = int'(from) + k;
      if (j >= N) j = j - N;
      jj = IDXW'(j);
      if (!found && v[jj]) begin
        sel   = jj;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Hold counter increment that saturates at MAX_HOLD-1 and never wraps.
  function automatic logic [HCW-1:0] hold_sat_inc(input logic [HCW-1:0] h);
    return (h >= HOLD_LAST) ? HOLD_LAST : h + HCW'(1);
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDXW-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  logic [IDXW-1:0] ptr;
  logic [HCW-1:0]  hold_cnt;

  logic [N-1:0]    others;
  logic            own_hit;
  logic            do_switch;
  logic [IDXW-1:0] pick;
  logic [N-1:0]    grant_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic [IDXW-1:0] ptr_nxt;
  logic [HCW-1:0]  hold_nxt;

  // Decision stage: next grant from the current owner and the sampled req.
  // While a grant is held, ptr equals the grantee's index, so a search of
  // "others" starting after ptr is the same as a search starting at i+1.
  always_comb begin
    others    = req & ~grant;
    own_hit   = |(req & grant);
    pick      = rr_pick(grant_vld ? others : req, ptr);
    do_switch = 1'b0;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;

    if (!grant_vld) begin
      do_switch = |req;
    end else if (!own_hit) begin
      if (|others) begin
        do_switch = 1'b1;
      end else begin
        grant_nxt = '0;
        idx_nxt   = '0;
        hold_nxt  = '0;
      end
    end else if (!(|others)) begin
      hold_nxt = hold_sat_inc(hold_cnt);
    end else if (hold_cnt < HOLD_LAST) begin
      hold_nxt = hold_sat_inc(hold_cnt);
    end else begin
      do_switch = 1'b1;
    end

    if (do_switch) begin
      grant_nxt = to_onehot(pick);
      idx_nxt   = pick;
      ptr_nxt   = pick;
      hold_nxt  = '0;
    end
  end

  // Register stage: registered grant outputs and arbitration state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
      ptr       <= PTR_RST;
      hold_cnt  <= '0;
    end else begin
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
      grant_vld <= |grant_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: a 4-way, MAX_HOLD=2 instance driven by directed
// sequences and random requests against a behavioural model, plus a 32-way,
// MAX_HOLD=1 instance for the rotation fairness check.
module tb_rr_arbiter_n;

  localparam int N4  = 4;
  localparam int MH4 = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req4;
  logic [3:0]  grant4;
  logic [1:0]  grant_idx4;
  logic        grant_vld4;
  logic [31:0] req32;
  logic [31:0] grant32;
  logic [4:0]  grant_idx32;
  logic        grant_vld32;

  int nvec;
  int nerr;

  // model state: owner (-1 = idle), last granted index, hold count
  int m_own;
  int m_ptr;
  int m_hold;

  rr_arbiter_n #(.N(N4), .MAX_HOLD(MH4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .req       (req4),
    .grant     (grant4),
    .grant_idx (grant_idx4),
    .grant_vld (grant_vld4)
  );

  rr_arbiter_n #(.N(32), .MAX_HOLD(1)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .req       (req32),
    .grant     (grant32),
    .grant_idx (grant_idx32),
    .grant_vld (grant_vld32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!$isunknown(req4) && !$isunknown(req32))
      else $error("unknown value on req");
  end

  always @(negedge clk) begin
    assert ($onehot0(grant4) && $onehot0(grant32))
      else $error("grant not one-hot");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int search(input logic [3:0] v, input int from);
    for (int k = 1; k <= N4; k++) begin
      if (v[(from + k) % N4]) return (from + k) % N4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_ptr  = N4 - 1;
    m_hold = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    if (m_own < 0) begin
      if (r != 4'b0) begin
        m_own  = search(r, m_ptr);
        m_ptr  = m_own;
        m_hold = 0;
      end
    end else begin
      others = r & ~(4'b0001 << m_own);
      if (!r[m_own]) begin
        if (others == 4'b0) begin
          m_own = -1;
        end else begin
          m_own  = search(others, m_own);
          m_ptr  = m_own;
          m_hold = 0;
        end
      end else if (others == 4'b0) begin
        m_hold = (m_hold + 1 > MH4 - 1) ? MH4 - 1 : m_hold + 1;
      end else if (m_hold < MH4 - 1) begin
        m_hold = m_hold + 1;
      end else begin
        m_own  = search(others, m_own);
        m_ptr  = m_own;
        m_hold = 0;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic cyc(input logic [3:0] r);
    logic [3:0] eg;
    req4 = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    eg = (m_own < 0) ? 4'b0 : (4'b0001 << m_own);
    chk("grant", 32'(grant4), 32'(eg));
    chk("grant_idx", 32'(grant_idx4), (m_own < 0) ? 32'd0 : 32'(m_own));
    chk("grant_vld", 32'(grant_vld4), (m_own < 0) ? 32'd0 : 32'd1);
  endtask

  // Asserts reset between edges and checks that the outputs clear at once.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant4), 32'd0);
    chk("rst_vld", 32'(grant_vld4), 32'd0);
    chk("rst_idx", 32'(grant_idx4), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [3:0] seq3 [10];
  logic [3:0] seq5 [4];
  int         cnt32 [32];
  logic [3:0] r;

  initial begin
    nvec  = 0;
    nerr  = 0;
    req4  = 4'b0;
    req32 = 32'b0;
    rst   = 1'b0;
    model_reset();
    seq3 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
             4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    seq5 = '{4'b0001, 4'b0001, 4'b0100, 4'b0100};

    @(negedge clk);
    chk("reset_grant", 32'(grant4), 32'd0);
    chk("reset_idx", 32'(grant_idx4), 32'd0);
    chk("reset_vld", 32'(grant_vld4), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // reset mid-grant, then first grant after release from ptr=N-1
    cyc(4'b0100);
    chk("t1_pre", 32'(grant4), 32'b0100);
    async_reset();
    cyc(4'b1010);
    chk("t1_grant", 32'(grant4), 32'b0010);
    chk("t1_idx", 32'(grant_idx4), 32'd1);

    // single requester holds, then releases
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0001);
      chk("t2_hold", 32'(grant4), 32'b0001);
    end
    cyc(4'b0000);
    chk("t2_idle", 32'(grant4), 32'd0);

    // full contention rotation
    async_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(4'b1111);
      chk("t3_seq", 32'(grant4), 32'(seq3[i]));
    end

    // early release hands over without an idle cycle
    async_reset();
    cyc(4'b1111);
    cyc(4'b1111);
    cyc(4'b1111);
    chk("t4_pre", 32'(grant4), 32'b0010);
    cyc(4'b1101);
    chk("t4_next", 32'(grant4), 32'b0100);

    // pointer kept across idle
    cyc(4'b0100);
    cyc(4'b0000);
    chk("t5_idle", 32'(grant4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0101);
      chk("t5_seq", 32'(grant4), 32'(seq5[i]));
    end

    // random requests against the model, with occasional async resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
      end else begin
        r = 4'($urandom);
        if ($urandom_range(0, 2) == 0) r = r & 4'($urandom);
        cyc(r);
      end
    end

    // 32-way rotation fairness with MAX_HOLD=1
    async_reset();
    for (int i = 0; i < 32; i++) cnt32[i] = 0;
    for (int k = 0; k < 64; k++) begin
      req32 = '1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_idx", 32'(grant_idx32), 32'(k % 32));
      chk("t6_grant", grant32, 32'b1 << (k % 32));
      cnt32[grant_idx32]++;
    end
    for (int i = 0; i < 32; i++) chk("t6_count", 32'(cnt32[i]), 32'd2);
    req32 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
